// File: rtl/mem_lsu_if.sv
// Data-memory port of the MEM stage: request/ack handshake with a
// single-cycle ack that carries load data in the same cycle.
interface mem_lsu_if;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_wdata_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;

  modport master (
    output mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o,
    input  mem_ack_i, mem_rdata_i
  );

  modport slave (
    input  mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o,
    output mem_ack_i, mem_rdata_i
  );
endinterface

// File: rtl/mem_lsu.sv
// mem_lsu: MEM pipeline stage. Non-memory results are registered straight
// through; loads/stores run a request/ack transaction on the data port and
// hold the upstream pipeline via stall_req_o until memory answers or the
// WAIT timeout expires.
// Optional feature: define MEM_ALIGN_CHECK_EN to reject misaligned
// halfword/word accesses (no request, err_o pulse, wreg_o=0).
module mem_lsu #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_i,
  input  logic [7:0]  aluop_i,
  input  logic [4:0]  wd_i,
  input  logic        wreg_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] reg2_i,
  mem_lsu_if.master   mem,
  output logic        stall_req_o,
  output logic        valid_o,
  output logic [4:0]  wd_o,
  output logic        wreg_o,
  output logic [31:0] wdata_o,
  output logic        err_o
);

  localparam int DATA_W = 32;

  localparam logic [7:0] OP_LB  = 8'b1110_0000;
  localparam logic [7:0] OP_LBU = 8'b1110_0100;
  localparam logic [7:0] OP_LH  = 8'b1110_0001;
  localparam logic [7:0] OP_LHU = 8'b1110_0101;
  localparam logic [7:0] OP_LW  = 8'b1110_0011;
  localparam logic [7:0] OP_SB  = 8'b1110_1000;
  localparam logic [7:0] OP_SH  = 8'b1110_1001;
  localparam logic [7:0] OP_SW  = 8'b1110_1011;

  // Counter only needs to reach TIMEOUT_CYCLES-1; the abort fires on that WAIT cycle.
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  function automatic logic is_load(input logic [7:0] op);
    return (op == OP_LB) || (op == OP_LBU) || (op == OP_LH) ||
           (op == OP_LHU) || (op == OP_LW);
  endfunction

  function automatic logic is_store(input logic [7:0] op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

  function automatic logic [3:0] lane_be(input logic [7:0] op, input logic [1:0] off);
    case (op)
      OP_SB:   return 4'b0001 << off;
      OP_SH:   return off[1] ? 4'b1100 : 4'b0011;
      default: return 4'hF;
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] lane_wdata(input logic [7:0] op, input logic [DATA_W-1:0] d);
    case (op)
      OP_SB:   return {4{d[7:0]}};
      OP_SH:   return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  // Select the addressed lane and sign/zero-extend it into the register width.
  function automatic logic [DATA_W-1:0] fmt_load(input logic [7:0] op, input logic [1:0] off,
                                                 input logic [DATA_W-1:0] rd);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    b = rd[8*off +: 8];
    h = off[1] ? rd[31:16] : rd[15:0];
    case (op)
      OP_LB:   return DATA_W'(b);
      OP_LBU:  return {24'b0, b};
      OP_LH:   return DATA_W'(h);
      OP_LHU:  return {16'b0, h};
      default: return rd;
    endcase
  endfunction

`ifdef MEM_ALIGN_CHECK_EN
  function automatic logic misaligned(input logic [7:0] op, input logic [1:0] off);
    case (op)
      OP_LH, OP_LHU, OP_SH: return off[0];
      OP_LW, OP_SW:         return off != 2'b00;
      default:              return 1'b0;
    endcase
  endfunction
`endif

  state_t            state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic              pass, accept, complete, tmo, misal;

  logic [7:0]        op_p0;
  logic [1:0]        off_p0;
  logic [4:0]        wd_p0;
  logic              wreg_p0;

  // State and WAIT-cycle counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // Next state, stall request and the per-cycle event strobes.
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    stall_req_o = 1'b0;
    pass        = 1'b0;
    accept      = 1'b0;
    complete    = 1'b0;
    tmo         = 1'b0;
    misal       = 1'b0;
    case (state)
      S_IDLE: begin
        if (valid_i) begin
          if (is_load(aluop_i) || is_store(aluop_i)) begin
`ifdef MEM_ALIGN_CHECK_EN
            if (misaligned(aluop_i, mem_addr_i[1:0])) begin
              misal = 1'b1;
            end else begin
              accept      = 1'b1;
              stall_req_o = 1'b1;
              state_n     = S_WAIT;
              cnt_n       = '0;
            end
`else
            accept      = 1'b1;
            stall_req_o = 1'b1;
            state_n     = S_WAIT;
            cnt_n       = '0;
`endif
          end else begin
            pass = 1'b1;
          end
        end
      end
      S_WAIT: begin
        stall_req_o = ~mem.mem_ack_i;
        if (mem.mem_ack_i) begin
          complete = 1'b1;
          state_n  = S_IDLE;
        end else if ((TIMEOUT_CYCLES != 0) && (cnt == TO_LAST)) begin
          tmo     = 1'b1;
          state_n = S_IDLE;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Memory request context and the registered MEM/WB result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem.mem_req_o   <= 1'b0;
      mem.mem_we_o    <= 1'b0;
      mem.mem_addr_o  <= '0;
      mem.mem_be_o    <= '0;
      mem.mem_wdata_o <= '0;
      op_p0           <= '0;
      off_p0          <= '0;
      wd_p0           <= '0;
      wreg_p0         <= 1'b0;
      valid_o         <= 1'b0;
      wd_o            <= '0;
      wreg_o          <= 1'b0;
      wdata_o         <= '0;
      err_o           <= 1'b0;
    end else begin
      valid_o <= 1'b0;
      wreg_o  <= 1'b0;
      err_o   <= 1'b0;
      if (pass) begin
        valid_o <= 1'b1;
        wd_o    <= wd_i;
        wreg_o  <= wreg_i;
        wdata_o <= wdata_i;
      end
      if (accept) begin
        mem.mem_req_o   <= 1'b1;
        mem.mem_we_o    <= is_store(aluop_i);
        mem.mem_addr_o  <= {mem_addr_i[31:2], 2'b00};
        mem.mem_be_o    <= lane_be(aluop_i, mem_addr_i[1:0]);
        mem.mem_wdata_o <= lane_wdata(aluop_i, reg2_i);
        op_p0           <= aluop_i;
        off_p0          <= mem_addr_i[1:0];
        wd_p0           <= wd_i;
        wreg_p0         <= wreg_i;
      end
      if (misal) begin
        valid_o <= 1'b1;
        wd_o    <= wd_i;
        err_o   <= 1'b1;
      end
      if (complete) begin
        mem.mem_req_o <= 1'b0;
        valid_o       <= 1'b1;
        wd_o          <= wd_p0;
        wreg_o        <= is_load(op_p0) & wreg_p0;
        wdata_o       <= is_load(op_p0) ? fmt_load(op_p0, off_p0, mem.mem_rdata_i) : '0;
      end
      if (tmo) begin
        mem.mem_req_o <= 1'b0;
        valid_o       <= 1'b1;
        wd_o          <= wd_p0;
        err_o         <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_lsu.sv
// Bench for mem_lsu: directed cases from the block description plus
// randomized load/store/pass-through traffic against a lane-arithmetic model.
module tb_mem_lsu;

  localparam int TO = 8;

  localparam logic [7:0] OP_LB  = 8'b1110_0000;
  localparam logic [7:0] OP_LBU = 8'b1110_0100;
  localparam logic [7:0] OP_LH  = 8'b1110_0001;
  localparam logic [7:0] OP_LHU = 8'b1110_0101;
  localparam logic [7:0] OP_LW  = 8'b1110_0011;
  localparam logic [7:0] OP_SB  = 8'b1110_1000;
  localparam logic [7:0] OP_SH  = 8'b1110_1001;
  localparam logic [7:0] OP_SW  = 8'b1110_1011;

  logic        clk;
  logic        rst;
  logic        valid_i;
  logic [7:0]  aluop_i;
  logic [4:0]  wd_i;
  logic        wreg_i;
  logic [31:0] wdata_i;
  logic [31:0] mem_addr_i;
  logic [31:0] reg2_i;
  logic        stall_req_o;
  logic        valid_o;
  logic [4:0]  wd_o;
  logic        wreg_o;
  logic [31:0] wdata_o;
  logic        err_o;

  int n_chk  = 0;
  int n_pass = 0;

  mem_lsu_if mem_bus ();

  mem_lsu #(.TIMEOUT_CYCLES(TO)) dut (
    .clk         (clk),
    .rst         (rst),
    .valid_i     (valid_i),
    .aluop_i     (aluop_i),
    .wd_i        (wd_i),
    .wreg_i      (wreg_i),
    .wdata_i     (wdata_i),
    .mem_addr_i  (mem_addr_i),
    .reg2_i      (reg2_i),
    .mem         (mem_bus),
    .stall_req_o (stall_req_o),
    .valid_o     (valid_o),
    .wd_o        (wd_o),
    .wreg_o      (wreg_o),
    .wdata_o     (wdata_o),
    .err_o       (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // ---------------- reference model ----------------
  function automatic bit m_is_load(input logic [7:0] op);
    return op == OP_LB || op == OP_LBU || op == OP_LH || op == OP_LHU || op == OP_LW;
  endfunction

  function automatic bit m_is_store(input logic [7:0] op);
    return op == OP_SB || op == OP_SH || op == OP_SW;
  endfunction

  function automatic logic [3:0] m_be(input logic [7:0] op, input logic [31:0] addr);
    int a;
    a = int'(addr % 4);
    if (op == OP_SB) return 4'(1 << a);
    if (op == OP_SH) return 4'(3 << (2 * (a / 2)));
    return 4'hF;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [7:0] op, input logic [31:0] d);
    if (op == OP_SB) return (d % 256) * 32'h0101_0101;
    if (op == OP_SH) return (d % 65536) * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [31:0] m_load(input logic [7:0] op, input logic [31:0] addr,
                                         input logic [31:0] rd);
    longint bv, hv;
    int a;
    a  = int'(addr % 4);
    bv = longint'((rd >> (8 * a)) % 256);
    hv = longint'((rd >> (16 * (a / 2))) % 65536);
    case (op)
      OP_LB:   return 32'((bv >= 128) ? bv - 256 : bv);
      OP_LBU:  return 32'(bv);
      OP_LH:   return 32'((hv >= 32768) ? hv - 65536 : hv);
      OP_LHU:  return 32'(hv);
      default: return rd;
    endcase
  endfunction

  function automatic logic [7:0] pick_mem_op(input int i);
    case (i)
      0: return OP_LB;
      1: return OP_LBU;
      2: return OP_LH;
      3: return OP_LHU;
      4: return OP_LW;
      5: return OP_SB;
      6: return OP_SH;
      default: return OP_SW;
    endcase
  endfunction

  // ---------------- stimulus ----------------
  task automatic idle_inputs();
    valid_i    = 1'b0;
    aluop_i    = '0;
    wd_i       = '0;
    wreg_i     = 1'b0;
    wdata_i    = '0;
    mem_addr_i = '0;
    reg2_i     = '0;
  endtask

  // One instruction through the stage; delay = WAIT cycles before the ack cycle.
  task automatic do_op(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] reg2,
                       input logic [31:0] rdata, input logic [4:0] wd, input logic wreg,
                       input logic [31:0] wdata, input int delay);
    bit mop;
    mop = m_is_load(op) || m_is_store(op);
    @(negedge clk);
    valid_i = 1'b1; aluop_i = op; mem_addr_i = addr; reg2_i = reg2;
    wd_i = wd; wreg_i = wreg; wdata_i = wdata;
    #1 chk_eq("stall_accept", stall_req_o, mop);
    @(negedge clk);
    if (!mop) begin
      chk_eq("pass_valid", valid_o, 1);
      chk_eq("pass_wd", wd_o, wd);
      chk_eq("pass_wreg", wreg_o, wreg);
      chk_eq("pass_wdata", wdata_o, wdata);
      chk_eq("pass_req", mem_bus.mem_req_o, 0);
      idle_inputs();
      #1 chk_eq("pass_stall", stall_req_o, 0);
      return;
    end
    // Garbage on the inputs while waiting must not disturb the transaction.
    aluop_i = pick_mem_op(int'($urandom_range(0, 7)));
    mem_addr_i = $urandom; reg2_i = $urandom; wd_i = 5'($urandom); wreg_i = 1'($urandom);
    for (int k = 0; k <= delay; k++) begin
      chk_eq("wait_req", mem_bus.mem_req_o, 1);
      chk_eq("wait_we", mem_bus.mem_we_o, m_is_store(op));
      chk_eq("wait_addr", mem_bus.mem_addr_o, addr & 32'hFFFF_FFFC);
      chk_eq("wait_be", mem_bus.mem_be_o, m_be(op, addr));
      if (m_is_store(op)) chk_eq("wait_wdata", mem_bus.mem_wdata_o, m_wdata(op, reg2));
      chk_eq("wait_valid", valid_o, 0);
      if (k == delay) begin
        mem_bus.mem_ack_i = 1'b1; mem_bus.mem_rdata_i = rdata;
        #1 chk_eq("stall_ack", stall_req_o, 0);
      end else begin
        mem_bus.mem_rdata_i = $urandom;
        #1 chk_eq("stall_wait", stall_req_o, 1);
      end
      @(negedge clk);
      mem_bus.mem_ack_i = 1'b0; mem_bus.mem_rdata_i = $urandom;
    end
    chk_eq("done_req", mem_bus.mem_req_o, 0);
    chk_eq("done_valid", valid_o, 1);
    chk_eq("done_wd", wd_o, wd);
    chk_eq("done_wreg", wreg_o, m_is_load(op) ? wreg : 1'b0);
    if (m_is_load(op)) chk_eq("done_rdata", wdata_o, m_load(op, addr, rdata));
    chk_eq("done_err", err_o, 0);
    idle_inputs();
    #1 chk_eq("done_stall", stall_req_o, 0);
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    mem_bus.mem_ack_i = 1'b0;
    mem_bus.mem_rdata_i = '0;

    // Reset state
    repeat (2) @(negedge clk);
    chk_eq("rst_req", mem_bus.mem_req_o, 0);
    chk_eq("rst_valid", valid_o, 0);
    chk_eq("rst_wreg", wreg_o, 0);
    chk_eq("rst_err", err_o, 0);
    chk_eq("rst_stall", stall_req_o, 0);
    chk_eq("rst_addr", mem_bus.mem_addr_o, 0);
    chk_eq("rst_wdata", wdata_o, 0);
    rst = 1'b0;

    // Directed cases
    do_op(8'h25, 32'h0, 32'h0, 32'h0, 5'd5, 1'b1, 32'h1234, 0);
    do_op(OP_LB, 32'h103, 32'h0, 32'h80FF_FF7F, 5'd7, 1'b1, 32'h0, 0);
    do_op(OP_SH, 32'h22, 32'hAAAA_BEEF, 32'h0, 5'd3, 1'b1, 32'h0, 1);
    do_op(OP_LW, 32'h40, 32'h0, 32'hDEAD_BEEF, 5'd9, 1'b1, 32'h0, 5);
    do_op(OP_LH, 32'h1, 32'h0, 32'h1234_8001, 5'd2, 1'b1, 32'h0, 2);
    do_op(OP_SB, 32'h7, 32'h0000_00A5, 32'h0, 5'd1, 1'b1, 32'h0, 0);

    // Idle cycle: nothing valid
    @(negedge clk);
    @(negedge clk);
    chk_eq("idle_valid", valid_o, 0);
    chk_eq("idle_wreg", wreg_o, 0);

    // Timeout: no ack for TO WAIT cycles
    @(negedge clk);
    valid_i = 1'b1; aluop_i = OP_LW; mem_addr_i = 32'h200; wd_i = 5'd4; wreg_i = 1'b1;
    @(negedge clk);
    idle_inputs();
    for (int k = 0; k < TO; k++) begin
      chk_eq("to_req_held", mem_bus.mem_req_o, 1);
      chk_eq("to_stall_held", stall_req_o, 1);
      chk_eq("to_err_low", err_o, 0);
      @(negedge clk);
    end
    chk_eq("to_req_drop", mem_bus.mem_req_o, 0);
    chk_eq("to_err", err_o, 1);
    chk_eq("to_valid", valid_o, 1);
    chk_eq("to_wreg", wreg_o, 0);
    chk_eq("to_stall", stall_req_o, 0);
    @(negedge clk);
    chk_eq("to_err_once", err_o, 0);
    chk_eq("to_valid_once", valid_o, 0);

    // Randomized traffic
    for (int n = 0; n < 150; n++) begin
      logic [7:0] op;
      if ($urandom_range(0, 4) == 0) op = 8'($urandom % 128);
      else op = pick_mem_op(int'($urandom_range(0, 7)));
      do_op(op, $urandom, $urandom, $urandom, 5'($urandom), 1'($urandom), $urandom,
            int'($urandom_range(0, 4)));
    end

    // Reset during WAIT, then a stray ack
    @(negedge clk);
    valid_i = 1'b1; aluop_i = OP_LW; mem_addr_i = 32'h300; wd_i = 5'd6; wreg_i = 1'b1;
    @(negedge clk);
    idle_inputs();
    chk_eq("rw_req_before", mem_bus.mem_req_o, 1);
    rst = 1'b1;
    #1;
    chk_eq("rw_req_async", mem_bus.mem_req_o, 0);
    chk_eq("rw_valid", valid_o, 0);
    chk_eq("rw_stall", stall_req_o, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    mem_bus.mem_ack_i = 1'b1; mem_bus.mem_rdata_i = 32'h5555_AAAA;
    @(negedge clk);
    mem_bus.mem_ack_i = 1'b0;
    chk_eq("rw_stray_valid", valid_o, 0);
    chk_eq("rw_stray_req", mem_bus.mem_req_o, 0);
    @(negedge clk);
    chk_eq("rw_stray_valid2", valid_o, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
